voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphonic voice scheduler feeding NUM_VOICES waveform_generator instances.
- Accepts decoded MIDI channel messages over a valid/ready handshake.
- Assigns each note to a voice slot: retrigger a matching voice, else take a free voice, else steal the oldest voice.
- Drives one 16-bit note_vol word per voice: bit15 gate, [14:8] note, [7:0] volume.

Parameters:
- NUM_VOICES, 8, number of voice slots (2..16).
- MIDI_CHANNEL, 0, 4-bit channel accepted when OMNI=0.
- OMNI, 0, 1 = accept all channels.
- AGE_W, 8, width of the per-voice saturating age counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- midi_valid  in  1  message present.
- midi_ready  out  1  block can accept a message.
- midi_status  in  8  status byte.
- midi_data1  in  8  note / controller number; bit7 ignored.
- midi_data2  in  8  velocity / controller value; bit7 ignored.
- voice_note_vol  out  16*NUM_VOICES  voice i in bits [16i+15:16i].
- busy  out  1  high while not IDLE.
- steal_pulse  out  1  one-cycle pulse when a sounding voice is stolen.

Behaviour:
- Reset (reset=0, asynchronous):
  - all voice_note_vol = 16'h0000; all ages = 0.
  - FSM = IDLE; midi_ready=1; busy=0; steal_pulse=0.
  - Reset mid-scan abandons the message; no partial write.
- FSM states: IDLE, SCAN, COMMIT.
  - midi_ready = (state==IDLE).
  - Handshake = midi_valid & midi_ready. On handshake, latch the three bytes and classify.
- Classification:
  - Channel = status[3:0]. Any mismatch (OMNI=0) → IGNORE.
  - NOTE_ON: status[7:4]=9, vel>0.
  - NOTE_OFF: status[7:4]=8, or 9 with vel=0.
  - ALL_OFF: status[7:4]=B and data1 ∈ {120,123}.
  - Anything else → IGNORE.
- Transitions:
  - IGNORE: consumed, stay IDLE, no output change.
  - ALL_OFF: IDLE → COMMIT.
  - NOTE_ON / NOTE_OFF: IDLE → SCAN.
  - SCAN → COMMIT after the last index; COMMIT → IDLE always.
- SCAN: index i = 0..NUM_VOICES-1, one voice per cycle. Records:
  - match_idx: first voice with gate=1 and note==data1.
  - free_idx: first voice with gate=0.
  - oldest_idx: maximum age, lowest index on tie.
- COMMIT (single cycle); writes land on the clock edge that ends COMMIT:
  - NOTE_ON target = match_idx if found, else free_idx if found, else oldest_idx.
    - Write {1'b1, data1[6:0], {data2[6:0],data2[6]}}, so vel 127 → 255 and vel 1 → 2.
    - Target age ← 0. Every other gated voice age ← age+1, saturating at 2^AGE_W-1.
    - steal_pulse=1 for that cycle only when the oldest path is taken.
  - NOTE_OFF: if match found, write {1'b0, note unchanged, 8'h00}; else no change.
  - ALL_OFF: every voice gate=0, volume=0, notes retained, ages=0.
- Latency:
  - Handshake at edge T.
  - Notes: SCAN spans T+1..T+NUM_VOICES; COMMIT at T+NUM_VOICES+1; next acceptance at T+NUM_VOICES+2.
  - ALL_OFF: COMMIT at T+1.
- Invariants:
  - At most one gated voice per note number.
  - Ungated voices always carry volume 0.
  - Outputs come directly from registers; no combinational path from the inputs.
- midi_valid may drop or change while not ready; the latched copy is used.

Decomposition:
- synth_pkg:
  - msg_kind_t enum {MSG_IGNORE, MSG_NOTE_ON, MSG_NOTE_OFF, MSG_ALL_OFF}.
  - Status nibble constants 4'h8, 4'h9, 4'hB.
  - CC constants 120, 123.
  - note_vol field positions: GATE_BIT=15, NOTE_MSB=14, NOTE_LSB=8, VOL_MSB=7.
  - alloc_state_t enum {IDLE, SCAN, COMMIT}.
- One sub-module: voice_age_tracker. Holds per-voice saturating ages, applies allocate/clear updates, and reports age[i] for the scan.

Test Plan:
- Reset, then note-on 0x90/60/100 → after NUM_VOICES+1 cycles, voice0 = 16'hBCC9, others 0; midi_ready low for 9 cycles (N=8).
- Note-on 0x90 notes 60, 62, 64 → voices 0,1,2. Then 0x80/62/0 → voice1 = 16'h3E00. Then note 67 → reuses voice1 (lowest free).
- Note-on 0x90/60/127 while 60 sounds at vel 100 → same voice, volume 255, no other voice changes.
- Fill all 8 voices with notes 60..67, then note 70 → voice0 (oldest) gets 70, steal_pulse high one cycle. Next note 71 steals voice1.
- 0xB0/123/0 with 8 sounding voices → all gates/volumes 0 at T+2. 0x91 with OMNI=0 → consumed, no change. 0x90/60/0 → treated as note-off.
- Assert reset low mid-SCAN → all outputs 0 asynchronously; after release midi_ready=1 and the next note lands in voice0.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the polyphonic voice allocator: message
// classes, MIDI status/controller codes, note_vol field layout and FSM states.
package synth_pkg;

   typedef enum logic [1:0] {
      MSG_IGNORE   = 2'd0,
      MSG_NOTE_ON  = 2'd1,
      MSG_NOTE_OFF = 2'd2,
      MSG_ALL_OFF  = 2'd3
   } msg_kind_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } alloc_state_t;

   localparam logic [3:0] ST_NOTE_OFF = 4'h8;
   localparam logic [3:0] ST_NOTE_ON  = 4'h9;
   localparam logic [3:0] ST_CTRL     = 4'hB;

   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

   localparam int GATE_BIT = 15;
   localparam int NOTE_MSB = 14;
   localparam int NOTE_LSB = 8;
   localparam int VOL_MSB  = 7;

   // Decode one channel message; data byte bit7 is ignored throughout.
   function automatic msg_kind_t classify_msg(
      input logic [7:0] status,
      input logic [7:0] data1,
      input logic [7:0] data2,
      input logic       omni,
      input logic [3:0] channel
   );
      msg_kind_t kind;
      kind = MSG_IGNORE;
      if (omni || (status[3:0] == channel)) begin
         case (status[7:4])
            ST_NOTE_ON:  kind = (data2[6:0] != 7'd0) ? MSG_NOTE_ON : MSG_NOTE_OFF;
            ST_NOTE_OFF: kind = MSG_NOTE_OFF;
            ST_CTRL: begin
               if ((data1[6:0] == CC_ALL_SOUND_OFF) || (data1[6:0] == CC_ALL_NOTES_OFF)) begin
                  kind = MSG_ALL_OFF;
               end else begin
                  kind = MSG_IGNORE;
               end
            end
            default:     kind = MSG_IGNORE;
         endcase
      end else begin
         kind = MSG_IGNORE;
      end
      return kind;
   endfunction

   // Stretch 7-bit velocity to 8-bit volume so 127 maps to full scale.
   function automatic logic [7:0] vel_to_vol(input logic [6:0] vel);
      return {vel, vel[6]};
   endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice saturating age counters; an allocation zeroes the target and ages
// every other sounding voice, a clear zeroes all of them.
module voice_age_tracker
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 8,
   parameter int AGE_W      = 8,
   parameter int IDX_W      = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        alloc_en,
   input  logic [IDX_W-1:0]            alloc_idx,
   input  logic                        clear_all,
   input  logic [NUM_VOICES-1:0]       gate_vec,
   output logic [NUM_VOICES*AGE_W-1:0] ages
);

   localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

   logic [AGE_W-1:0] age_r [NUM_VOICES];

   // Age update on allocate / clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            age_r[i] <= {AGE_W{1'b0}};
         end
      end else if (clear_all) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            age_r[i] <= {AGE_W{1'b0}};
         end
      end else if (alloc_en) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (alloc_idx == IDX_W'(i)) begin
               age_r[i] <= {AGE_W{1'b0}};
            end else if (gate_vec[i] && (age_r[i] != AGE_MAX)) begin
               age_r[i] <= age_r[i] + {{(AGE_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_age_out
      assign ages[g*AGE_W +: AGE_W] = age_r[g];
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: classifies MIDI channel messages, scans the
// voice slots one per cycle, then retriggers / allocates / steals in COMMIT.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int         NUM_VOICES   = 8,
   parameter logic [3:0] MIDI_CHANNEL = 4'd0,
   parameter bit         OMNI         = 1'b0,
   parameter int         AGE_W        = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     midi_valid,
   output logic                     midi_ready,
   input  logic [7:0]               midi_status,
   input  logic [7:0]               midi_data1,
   input  logic [7:0]               midi_data2,
   output logic [16*NUM_VOICES-1:0] voice_note_vol,
   output logic                     busy,
   output logic                     steal_pulse
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   alloc_state_t state_r;
   msg_kind_t    kind_r;
   msg_kind_t    kind_s;
   logic [6:0]   note_r;
   logic [6:0]   vel_r;
   logic         ready_r;
   logic         busy_r;
   logic         steal_r;
   logic         handshake_s;

   logic [IDX_W-1:0] scan_idx_r;
   logic [IDX_W-1:0] match_idx_r;
   logic [IDX_W-1:0] free_idx_r;
   logic [IDX_W-1:0] oldest_idx_r;
   logic [IDX_W-1:0] target_idx_s;
   logic             match_found_r;
   logic             free_found_r;
   logic             steal_sel_s;
   logic [AGE_W-1:0] oldest_age_r;
   logic [AGE_W-1:0] cur_age_s;
   logic [15:0]      cur_word_s;

   logic [15:0]                  voice_r [NUM_VOICES];
   logic [AGE_W-1:0]             age_arr_s [NUM_VOICES];
   logic [NUM_VOICES*AGE_W-1:0]  ages_s;
   logic [NUM_VOICES-1:0]        gate_vec_s;
   logic                         alloc_en_s;
   logic                         clear_all_s;

   assign handshake_s = midi_valid & (state_r == IDLE);
   assign kind_s      = classify_msg(midi_status, midi_data1, midi_data2, OMNI, MIDI_CHANNEL);
   assign alloc_en_s  = (state_r == COMMIT) && (kind_r == MSG_NOTE_ON);
   assign clear_all_s = (state_r == COMMIT) && (kind_r == MSG_ALL_OFF);

   assign midi_ready  = ready_r;
   assign busy        = busy_r;
   assign steal_pulse = steal_r;

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      assign gate_vec_s[g]             = voice_r[g][GATE_BIT];
      assign age_arr_s[g]              = ages_s[g*AGE_W +: AGE_W];
      assign voice_note_vol[g*16 +: 16] = voice_r[g];
   end

   voice_age_tracker #(
      .NUM_VOICES (NUM_VOICES),
      .AGE_W      (AGE_W),
      .IDX_W      (IDX_W)
   ) u_age (
      .clk       (clk),
      .reset     (reset),
      .alloc_en  (alloc_en_s),
      .alloc_idx (target_idx_s),
      .clear_all (clear_all_s),
      .gate_vec  (gate_vec_s),
      .ages      (ages_s)
   );

   // Current scan slot and note-on target priority: match, then free, then oldest.
   always_comb begin
      cur_word_s = voice_r[scan_idx_r];
      cur_age_s  = age_arr_s[scan_idx_r];
      if (match_found_r) begin
         target_idx_s = match_idx_r;
         steal_sel_s  = 1'b0;
      end else if (free_found_r) begin
         target_idx_s = free_idx_r;
         steal_sel_s  = 1'b0;
      end else begin
         target_idx_s = oldest_idx_r;
         steal_sel_s  = 1'b1;
      end
   end

   // Control FSM with message latch and registered ready/busy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         kind_r     <= MSG_IGNORE;
         note_r     <= 7'd0;
         vel_r      <= 7'd0;
         scan_idx_r <= {IDX_W{1'b0}};
         ready_r    <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (handshake_s) begin
                  note_r     <= midi_data1[6:0];
                  vel_r      <= midi_data2[6:0];
                  kind_r     <= kind_s;
                  scan_idx_r <= {IDX_W{1'b0}};
                  case (kind_s)
                     MSG_NOTE_ON, MSG_NOTE_OFF: begin
                        state_r <= SCAN;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                     end
                     MSG_ALL_OFF: begin
                        state_r <= COMMIT;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                     end
                     default: begin
                        state_r <= IDLE;
                     end
                  endcase
               end
            end
            SCAN: begin
               if (scan_idx_r == LAST_IDX) begin
                  state_r <= COMMIT;
               end else begin
                  scan_idx_r <= scan_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end
            COMMIT: begin
               state_r <= IDLE;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Scan bookkeeping: first match, first free, oldest (strict > keeps lowest index).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         match_found_r <= 1'b0;
         match_idx_r   <= {IDX_W{1'b0}};
         free_found_r  <= 1'b0;
         free_idx_r    <= {IDX_W{1'b0}};
         oldest_idx_r  <= {IDX_W{1'b0}};
         oldest_age_r  <= {AGE_W{1'b0}};
      end else if (handshake_s) begin
         match_found_r <= 1'b0;
         match_idx_r   <= {IDX_W{1'b0}};
         free_found_r  <= 1'b0;
         free_idx_r    <= {IDX_W{1'b0}};
         oldest_idx_r  <= {IDX_W{1'b0}};
         oldest_age_r  <= {AGE_W{1'b0}};
      end else if (state_r == SCAN) begin
         if (!match_found_r && cur_word_s[GATE_BIT] && (cur_word_s[NOTE_MSB:NOTE_LSB] == note_r)) begin
            match_found_r <= 1'b1;
            match_idx_r   <= scan_idx_r;
         end
         if (!free_found_r && !cur_word_s[GATE_BIT]) begin
            free_found_r <= 1'b1;
            free_idx_r   <= scan_idx_r;
         end
         if (cur_age_s > oldest_age_r) begin
            oldest_age_r <= cur_age_s;
            oldest_idx_r <= scan_idx_r;
         end
      end
   end

   // Voice word updates, landing on the edge that ends COMMIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            voice_r[i] <= 16'h0000;
         end
         steal_r <= 1'b0;
      end else begin
         steal_r <= 1'b0;
         if (state_r == COMMIT) begin
            case (kind_r)
               MSG_NOTE_ON: begin
                  voice_r[target_idx_s] <= {1'b1, note_r, vel_to_vol(vel_r)};
                  steal_r               <= steal_sel_s;
               end
               MSG_NOTE_OFF: begin
                  if (match_found_r) begin
                     voice_r[match_idx_r] <= {1'b0, voice_r[match_idx_r][NOTE_MSB:NOTE_LSB], 8'h00};
                  end
               end
               MSG_ALL_OFF: begin
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     voice_r[i] <= {1'b0, voice_r[i][NOTE_MSB:NOTE_LSB], 8'h00};
                  end
               end
               default: begin
                  steal_r <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: stimulus pushes hand-computed expected
// voice words; a negedge monitor pops and compares on completion or probe.
module tb_voice_allocator;

   localparam int N = 8;

   logic              clk;
   logic              reset;
   logic              midi_valid;
   logic              midi_ready;
   logic [7:0]        midi_status;
   logic [7:0]        midi_data1;
   logic [7:0]        midi_data2;
   logic [16*N-1:0]   voice_note_vol;
   logic              busy;
   logic              steal_pulse;

   voice_allocator #(
      .NUM_VOICES   (N),
      .MIDI_CHANNEL (4'd0),
      .OMNI         (1'b0),
      .AGE_W        (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .midi_valid     (midi_valid),
      .midi_ready     (midi_ready),
      .midi_status    (midi_status),
      .midi_data1     (midi_data1),
      .midi_data2     (midi_data2),
      .voice_note_vol (voice_note_vol),
      .busy           (busy),
      .steal_pulse    (steal_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16*N-1:0] nv;
      logic            steal;
      int              len;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic [15:0] mv [N];
   int          n_vec = 0;
   int          n_bad = 0;
   int          low_cnt = 0;
   logic        prev_busy = 1'b0;
   logic        probe_req = 1'b0;
   logic        end_req = 1'b0;

   function automatic logic [15:0] mk(input logic g, input logic [6:0] n, input logic [7:0] v);
      return {g, n, v};
   endfunction

   task automatic push_exp(input logic steal, input int len);
      exp_t e;
      for (int i = 0; i < N; i++) e.nv[i*16 +: 16] = mv[i];
      e.steal = steal;
      e.len   = len;
      sb_q.push_back(e);
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) mv[i] = 16'h0000;
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (midi_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) begin
         $display("FAIL ready_timeout: midi_ready=%b required 1", midi_ready);
         $fatal(1, "ready timeout");
      end
   endtask

   task automatic handshake(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
      wait_ready();
      midi_valid  = 1'b1;
      midi_status = st;
      midi_data1  = d1;
      midi_data2  = d2;
      @(posedge clk); #1;
      midi_valid  = 1'b0;
      midi_status = 8'h9F;
      midi_data1  = 8'hFF;
      midi_data2  = 8'hFF;
   endtask

   task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
      handshake(st, d1, d2);
      wait_ready();
      @(negedge clk); #1;
   endtask

   task automatic probe();
      push_exp(1'b0, -1);
      probe_req = 1'b1;
      @(negedge clk); #1;
      probe_req = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      clear_model();
      probe();
   endtask

   // Monitor: compare on completion (busy falling) or on a probe request.
   always @(negedge clk) begin
      if (probe_req || (prev_busy === 1'b1 && busy === 1'b0)) begin
         if (sb_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_output: voice_note_vol=%h with no expectation", voice_note_vol);
         end else begin
            mon_e = sb_q.pop_front();
            n_vec++;
            if (voice_note_vol !== mon_e.nv) begin
               n_bad++;
               $display("FAIL voice_note_vol: got %h expected %h", voice_note_vol, mon_e.nv);
            end
            n_vec++;
            if (steal_pulse !== mon_e.steal) begin
               n_bad++;
               $display("FAIL steal_pulse: got %b expected %b", steal_pulse, mon_e.steal);
            end
            n_vec++;
            if (midi_ready !== 1'b1 || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL ready_busy: got ready=%b busy=%b expected ready=1 busy=0", midi_ready, busy);
            end
            if (mon_e.len >= 0) begin
               n_vec++;
               if (low_cnt != mon_e.len) begin
                  n_bad++;
                  $display("FAIL ready_low_cycles: got %0d expected %0d", low_cnt, mon_e.len);
               end
            end
         end
      end
      if (end_req) begin
         n_vec++;
         if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expectations: %0d left, expected 0", sb_q.size());
         end
      end
      if (midi_ready !== 1'b1) low_cnt++;
      else low_cnt = 0;
      prev_busy = busy;
   end

   initial begin
      midi_valid  = 1'b0;
      midi_status = 8'h00;
      midi_data1  = 8'h00;
      midi_data2  = 8'h00;
      reset       = 1'b1;
      clear_model();
      #1 reset = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      #1;
      probe();

      // First note lands in voice 0 after N+1 busy cycles.
      mv[0] = 16'hBCC9; push_exp(1'b0, N+1);
      send(8'h90, 8'd60, 8'd100);

      // Three notes, a note-off, then reuse of the lowest free slot.
      do_reset();
      mv[0] = 16'hBCC9; push_exp(1'b0, N+1); send(8'h90, 8'd60, 8'd100);
      mv[1] = 16'hBEC9; push_exp(1'b0, N+1); send(8'h90, 8'd62, 8'd100);
      mv[2] = 16'hC0C9; push_exp(1'b0, N+1); send(8'h90, 8'd64, 8'd100);
      mv[1] = 16'h3E00; push_exp(1'b0, N+1); send(8'h80, 8'd62, 8'd0);
      mv[1] = 16'hC3C9; push_exp(1'b0, N+1); send(8'h90, 8'd67, 8'd100);

      // Retrigger at full velocity, wrong channel ignored, vel 0 as note-off.
      mv[0] = 16'hBCFF; push_exp(1'b0, N+1); send(8'h90, 8'd60, 8'd127);
      send(8'h91, 8'd70, 8'd100);
      probe();
      mv[2] = 16'h4000; push_exp(1'b0, N+1); send(8'h90, 8'd64, 8'd0);
      mv[0] = 16'h3C00; mv[1] = 16'h4300; push_exp(1'b0, 1); send(8'hB0, 8'd123, 8'd0);

      // Fill all voices, then steal the two oldest in turn.
      do_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = mk(1'b1, 7'(60 + i), 8'hC9);
         push_exp(1'b0, N+1);
         send(8'h90, 8'(60 + i), 8'd100);
      end
      mv[0] = 16'hC6C9; push_exp(1'b1, N+1); send(8'h90, 8'd70, 8'd100);
      probe();
      mv[1] = 16'hC7C9; push_exp(1'b1, N+1); send(8'h90, 8'd71, 8'd100);
      send(8'hB0, 8'd121, 8'd0);
      send(8'hC0, 8'd5, 8'd0);
      probe();
      mv[0] = 16'h4600; mv[1] = 16'h4700;
      for (int i = 2; i < N; i++) mv[i] = mk(1'b0, 7'(60 + i), 8'h00);
      push_exp(1'b0, 1); send(8'hB0, 8'd120, 8'd0);

      // Minimum velocity and ignored data bit7.
      mv[0] = 16'hBD02; push_exp(1'b0, N+1); send(8'h90, 8'd61, 8'd1);
      mv[1] = 16'hBEC9; push_exp(1'b0, N+1); send(8'h90, 8'hBE, 8'hE4);

      // Reset during SCAN abandons the message and clears outputs at once.
      handshake(8'h90, 8'd65, 8'd100);
      repeat (3) @(posedge clk);
      #1;
      clear_model();
      push_exp(1'b0, -1);
      reset = 1'b0;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      probe();
      mv[0] = 16'hBCC9; push_exp(1'b0, N+1); send(8'h90, 8'd60, 8'd100);

      end_req = 1'b1;
      @(negedge clk); #1;
      end_req = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
